// File: rtl/input_capture_ff.sv
// input_capture_ff: pad input synchronizer with per-bit glitch filter and edge pulses.
// Stage 0 is written as a plain sync-reset flop so it packs into the IO-cell input register (IFS1P3IX/JX).
module input_capture_ff #(
  parameter int WIDTH = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int SAMPLE_DIV = 1,
  parameter int RESET_VALUE = 0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] PIN,
  output logic [WIDTH-1:0] LEVEL,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);
  localparam int PW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [WIDTH-1:0] RV = {WIDTH{1'(RESET_VALUE)}};
  (* syn_useioff = 1 *) logic [WIDTH-1:0] pad_q;
  logic [(SYNC_STAGES-1)*WIDTH-1:0] fab;
  logic [WIDTH-1:0] sync;
  logic [PW-1:0] pre;
  logic tick;
  logic [CW-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] acc;
  always_ff @(posedge CLOCK) pad_q <= RESET ? RV : PIN;
  if (SYNC_STAGES > 2) begin : g_deep
    always_ff @(posedge CLOCK) fab <= RESET ? {(SYNC_STAGES-1){RV}} : {fab[(SYNC_STAGES-2)*WIDTH-1:0], pad_q};
  end else begin : g_one
    always_ff @(posedge CLOCK) fab <= RESET ? RV : pad_q;
  end
  assign sync = fab[(SYNC_STAGES-1)*WIDTH-1 -: WIDTH];
  assign tick = pre == PW'(SAMPLE_DIV - 1);
  // a bit is accepted on the tick where its differing run reaches FILTER_CYCLES samples
  always_comb begin
    acc = '0;
    for (int k = 0; k < WIDTH; k++) acc[k] = tick && sync[k] != LEVEL[k] && cnt[k] == CW'(FILTER_CYCLES - 1);
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pre <= '0;
      LEVEL <= RV;
      RISE <= '0;
      FALL <= '0;
      for (int k = 0; k < WIDTH; k++) cnt[k] <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      LEVEL <= LEVEL ^ acc;
      RISE <= acc & sync;
      FALL <= acc & ~sync;
      for (int k = 0; k < WIDTH; k++)
        if (tick) cnt[k] <= (sync[k] != LEVEL[k] && !acc[k]) ? cnt[k] + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_input_capture_ff.sv
// tb_input_capture_ff: scoreboard bench for the input capture filter.
// Three instances: defaults (WIDTH=2), RESET_VALUE=1, SAMPLE_DIV=3.
module tb_input_capture_ff;
  logic CLOCK = 0, RESET = 1;
  logic [1:0] pin = 0, pin_rv = 2'b11, pin_d3 = 0;
  logic [1:0] lvl, rise, fall, lvl_rv, rise_rv, fall_rv, lvl_d3, rise_d3, fall_d3;
  int cyc = 0, n_chk = 0, n_fail = 0, rst_edge = 0;
  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  input_capture_ff #(.WIDTH(2)) dut (.CLOCK(CLOCK), .RESET(RESET), .PIN(pin), .LEVEL(lvl), .RISE(rise), .FALL(fall));
  input_capture_ff #(.WIDTH(2), .RESET_VALUE(1)) dut_rv (.CLOCK(CLOCK), .RESET(RESET), .PIN(pin_rv), .LEVEL(lvl_rv), .RISE(rise_rv), .FALL(fall_rv));
  input_capture_ff #(.WIDTH(2), .SAMPLE_DIV(3)) dut_d3 (.CLOCK(CLOCK), .RESET(RESET), .PIN(pin_d3), .LEVEL(lvl_d3), .RISE(rise_d3), .FALL(fall_d3));

  // expected outputs of one instance after edge number 'at'
  typedef struct {int at; int sel; int tid; logic [1:0] l; logic [1:0] r; logic [1:0] f;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [1:0] gl, gr, gf;

  function automatic void push(int at, int sel, int tid, logic [1:0] l, logic [1:0] r, logic [1:0] f);
    exp_t x;
    x.at = at; x.sel = sel; x.tid = tid; x.l = l; x.r = r; x.f = f;
    sb.push_back(x);
  endfunction

  always @(negedge CLOCK)
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      gl = e.sel == 0 ? lvl : e.sel == 1 ? lvl_rv : lvl_d3;
      gr = e.sel == 0 ? rise : e.sel == 1 ? rise_rv : rise_d3;
      gf = e.sel == 0 ? fall : e.sel == 1 ? fall_rv : fall_d3;
      n_chk++;
      if (e.at != cyc || {gl, gr, gf} !== {e.l, e.r, e.f}) begin
        n_fail++;
        $display("FAIL sb t%0d dut%0d cyc %0d (exp cyc %0d): got lvl=%b rise=%b fall=%b, expected lvl=%b rise=%b fall=%b",
                 e.tid, e.sel, cyc, e.at, gl, gr, gf, e.l, e.r, e.f);
      end
    end

  // property monitor on the default instance, active during the random test
  logic [1:0] s1 = 0, s2 = 0, ps2 = 0, plvl = 0;
  logic rst_q = 1;
  int run [2];
  bit mon_on = 0;
  always @(posedge CLOCK) begin
    rst_q <= RESET;
    s1 <= RESET ? 2'b00 : pin;
    s2 <= RESET ? 2'b00 : s1;
  end
  always @(negedge CLOCK) begin
    if (mon_on) begin
      n_chk++;
      if ((rise & fall) !== 2'b00) begin
        n_fail++;
        $display("FAIL rise_fall_overlap cyc %0d: rise=%b fall=%b, overlap must be 00", cyc, rise, fall);
      end
      if (!rst_q) begin
        n_chk++;
        if (rise !== (lvl & ~plvl) || fall !== (~lvl & plvl)) begin
          n_fail++;
          $display("FAIL pulse_match cyc %0d: level %b->%b rise=%b fall=%b", cyc, plvl, lvl, rise, fall);
        end
      end
    end
    for (int b = 0; b < 2; b++) begin
      run[b] = (rst_q || ps2[b] === plvl[b]) ? 0 : run[b] + 1;
      if (mon_on && !rst_q) begin
        n_chk++;
        if ((lvl[b] !== plvl[b]) != (run[b] == 4)) begin
          n_fail++;
          $display("FAIL filter bit%0d cyc %0d: level change=%0d after %0d differing samples, change required iff 4",
                   b, cyc, lvl[b] !== plvl[b], run[b]);
        end
      end
      if (lvl[b] !== plvl[b]) run[b] = 0;
    end
    ps2 = s2;
    plvl = lvl;
  end

  task automatic do_reset(int n);
    @(negedge CLOCK);
    RESET = 1;
    repeat (n) @(negedge CLOCK);
    RESET = 0;
    rst_edge = cyc;
  endtask

  task automatic wait_sb();
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge CLOCK);
  endtask

  task automatic test_reset();
    pin = 2'b00; pin_rv = 2'b11; pin_d3 = 2'b00;
    do_reset(2);
    n_chk++;
    if ({lvl, rise, fall, lvl_rv, rise_rv, fall_rv} !== 12'b00_00_00_11_00_00) begin
      n_fail++;
      $display("FAIL reset_state: got %b/%b/%b rv %b/%b/%b, expected 00/00/00 rv 11/00/00", lvl, rise, fall, lvl_rv, rise_rv, fall_rv);
    end
    for (int k = 1; k <= 20; k++) begin
      push(cyc + k, 0, 1, 2'b00, 2'b00, 2'b00);
      push(cyc + k, 1, 1, 2'b11, 2'b00, 2'b00);
    end
    wait_sb();
  endtask

  task automatic test_rise();
    int t0;
    @(negedge CLOCK);
    pin[0] = 1;
    t0 = cyc + 1;
    for (int k = 0; k < 8; k++) push(t0 + k, 0, 2, k >= 5 ? 2'b01 : 2'b00, k == 5 ? 2'b01 : 2'b00, 2'b00);
    wait_sb();
    n_chk++;
    if (lvl !== 2'b01 || rise !== 2'b00) begin
      n_fail++;
      $display("FAIL rise_settle: lvl=%b rise=%b, expected 01/00", lvl, rise);
    end
  endtask

  task automatic test_glitch();
    int t0;
    @(negedge CLOCK);
    pin[1] = 1;
    t0 = cyc + 1;
    for (int k = 0; k < 11; k++) push(t0 + k, 0, 3, 2'b01, 2'b00, 2'b00);
    repeat (3) @(negedge CLOCK);
    pin[1] = 0;
    wait_sb();
    n_chk++;
    if (lvl !== 2'b01) begin
      n_fail++;
      $display("FAIL glitch3: lvl=%b, expected 01", lvl);
    end
    @(negedge CLOCK);
    pin[1] = 1;
    t0 = cyc + 1;
    for (int k = 0; k < 12; k++)
      push(t0 + k, 0, 4, (k >= 5 && k < 9) ? 2'b11 : 2'b01, k == 5 ? 2'b10 : 2'b00, k == 9 ? 2'b10 : 2'b00);
    repeat (4) @(negedge CLOCK);
    pin[1] = 0;
    wait_sb();
  endtask

  task automatic test_div3();
    int t0, ex;
    @(negedge CLOCK);
    for (int k = 0; k < 3 && ((cyc + 3 - rst_edge) % 3) != 1; k++) @(negedge CLOCK);
    pin_d3[1] = 1;
    t0 = cyc + 1;
    for (int k = 0; k < 15; k++) push(t0 + k, 2, 5, 2'b00, 2'b00, 2'b00);
    repeat (2) @(negedge CLOCK);
    pin_d3[1] = 0;
    wait_sb();
    @(negedge CLOCK);
    pin_d3[0] = 1;
    t0 = cyc + 1;
    ex = t0 + 2;
    while (((ex - rst_edge) % 3) != 0) ex++;
    ex += 9;
    for (int k = t0; k <= ex + 2; k++) push(k, 2, 6, k >= ex ? 2'b01 : 2'b00, k == ex ? 2'b01 : 2'b00, 2'b00);
    for (int k = 0; k < 20 && lvl_d3[0] !== 1'b1; k++) @(negedge CLOCK);
    n_chk++;
    if (lvl_d3[0] !== 1'b1 || cyc > t0 + 13 || ((cyc - rst_edge) % 3) != 0) begin
      n_fail++;
      $display("FAIL div3_latency: level=%b at cyc %0d, required by cyc %0d on a tick edge", lvl_d3[0], cyc, t0 + 13);
    end
    wait_sb();
  endtask

  task automatic test_both_and_midreset();
    int t0;
    pin = 2'b00; pin_d3 = 2'b00;
    do_reset(1);
    @(negedge CLOCK);
    pin = 2'b11;
    t0 = cyc + 1;
    for (int k = 0; k < 8; k++) push(t0 + k, 0, 7, k >= 5 ? 2'b11 : 2'b00, k == 5 ? 2'b11 : 2'b00, 2'b00);
    wait_sb();
    @(negedge CLOCK);
    pin[0] = 0;
    t0 = cyc + 1;
    for (int k = 0; k < 4; k++) push(t0 + k, 0, 8, 2'b11, 2'b00, 2'b00);
    repeat (4) @(negedge CLOCK);
    RESET = 1;
    @(negedge CLOCK);
    RESET = 0;
    rst_edge = cyc;
    n_chk++;
    if ({lvl, rise, fall} !== 6'b00_00_00) begin
      n_fail++;
      $display("FAIL mid_reset: got %b/%b/%b, expected 00/00/00", lvl, rise, fall);
    end
    for (int k = 1; k < 9; k++) push(rst_edge + k, 0, 9, k >= 6 ? 2'b10 : 2'b00, k == 6 ? 2'b10 : 2'b00, 2'b00);
    wait_sb();
  endtask

  task automatic test_random();
    pin = 2'b00;
    do_reset(1);
    mon_on = 1;
    repeat (600) begin
      @(negedge CLOCK);
      for (int b = 0; b < 2; b++) if ($urandom_range(3) == 0) pin[b] = ~pin[b];
      RESET = $urandom_range(49) == 0;
    end
    @(negedge CLOCK);
    RESET = 0;
    repeat (10) @(negedge CLOCK);
    mon_on = 0;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_div3();
    test_both_and_midreset();
    test_random();
    @(negedge CLOCK);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/input_capture_ff.md
# input_capture_ff

Input-side counterpart of the registered output path: captures asynchronous pad inputs in the ECP5 IO-cell input register, synchronizes them into the fabric clock domain, rejects glitches with a per-bit consecutive-sample filter and reports clean levels plus single-cycle edge pulses. It sits between top-level input pads and any consumer logic: buttons, handshake lines from external chips, slow status strobes. One instance covers a bus of `WIDTH` independent bits.

## Interface
- `WIDTH`, 1: number of independent input bits.
- `SYNC_STAGES`, 2: total synchronizer depth including the IO-cell flop; legal range 2..4.
- `FILTER_CYCLES`, 4: consecutive differing sample ticks required to accept a new level; legal range 1..255.
- `SAMPLE_DIV`, 1: sample tick period in clocks; 1 means a tick every cycle; legal range 1..65535.
- `RESET_VALUE`, 0: level (0 or 1) of every synchronizer stage and `LEVEL` bit after reset.

- `CLOCK`  in  1  fabric clock, rising edge.
- `RESET`  in  1  reset RESET, synchronous, active-high.
- `PIN`    in  WIDTH  raw pad inputs, asynchronous to `CLOCK`.
- `LEVEL`  out  WIDTH  filtered, synchronized level per bit.
- `RISE`   out  WIDTH  one-cycle pulse when the corresponding `LEVEL` bit goes 0→1.
- `FALL`   out  WIDTH  one-cycle pulse when the corresponding `LEVEL` bit goes 1→0.

## Operation
- Stage 0 is the IO-cell input register: IFS1P3IX (sync clear) when `RESET_VALUE`=0, IFS1P3JX (sync preset) when 1; SP tied high, CD/PD driven by `RESET`. Stages 1..`SYNC_STAGES`-1 are fabric flops with the same reset value. The last stage is `sync[i]`.
- Prescaler: shared counter 0..`SAMPLE_DIV`-1, increments every cycle, wraps to 0; `tick` asserts in the cycle the counter equals `SAMPLE_DIV`-1. With `SAMPLE_DIV`=1 `tick` is constantly 1. Counter width is `$clog2(SAMPLE_DIV)`, minimum 1.
- Per-bit filter counter `cnt[i]`, width `$clog2(FILTER_CYCLES+1)`, minimum 1. Updated only on `tick`:
  - `sync[i]` == `LEVEL[i]`: `cnt[i]` ← 0.
  - differs and `cnt[i]` == `FILTER_CYCLES`-1: accept. `LEVEL[i]` ← `sync[i]`, `cnt[i]` ← 0, and `RISE[i]` or `FALL[i]` asserts for the following cycle.
  - differs otherwise: `cnt[i]` ← `cnt[i]`+1. The counter never exceeds `FILTER_CYCLES`-1.
- No tick: `cnt` and `LEVEL` hold. `RISE`/`FALL` are 0 in every cycle that is not the cycle right after an accept.
- Bits are fully independent; simultaneous accepts on several bits produce simultaneous pulses.
- A glitch shorter than `FILTER_CYCLES` ticks resets the count and produces no change. A return to the old level at any tick restarts the count from 0.
- `RISE` and `FALL` of one bit are never both 1.

## Timing
- Reset (`RESET` high at a rising edge): all synchronizer stages and `LEVEL` ← `RESET_VALUE`; `cnt` ← 0; prescaler ← 0; `RISE` = `FALL` = 0. This applies in mid-operation too: any pending count is discarded. No edge pulse occurs in the cycle after reset is released, because the stages already equal `LEVEL`.
- Latency with `SAMPLE_DIV`=1: `PIN` stable at its new value before edge t0 → `LEVEL` changes and the edge pulse is high after edge t0+`SYNC_STAGES`+`FILTER_CYCLES`-1. Defaults give t0+5.
- With `SAMPLE_DIV`>1, latency is bounded by `SYNC_STAGES`-1+`FILTER_CYCLES`·`SAMPLE_DIV` cycles and is tick-aligned.
- Every output is a direct register output; there is no combinational path from `PIN` to any output.
- Pulse width is exactly 1 `CLOCK` cycle. The minimum spacing between consecutive pulses on one bit is `FILTER_CYCLES`·`SAMPLE_DIV` cycles.

## Test plan
All scenarios use defaults except `WIDTH`=2.
- Reset, then `PIN`=2'b00 held: `LEVEL`=00 and `RISE`=`FALL`=00 for 20 cycles. With `RESET_VALUE`=1 and `PIN`=11, `LEVEL`=11 and no pulses.
- `PIN[0]` 0→1 before edge t0: `LEVEL[0]`=1 and `RISE[0]`=1 after edge t0+5 only, `RISE[0]`=0 after t0+6; bit 1 unaffected.
- `PIN[1]` high-pulse of 3 cycles, then 0: `LEVEL[1]` stays 0 and no `RISE[1]`. A 4-cycle pulse gives `RISE[1]`, then `FALL[1]` 4 cycles after the return to 0 is synchronized.
- `SAMPLE_DIV`=3, `PIN[0]` 0→1: `LEVEL[0]` rises no later than 1+12 cycles after sync, on a tick cycle. A 2-cycle pulse between ticks is never counted.
- Both bits toggle 0→1 in the same cycle: `RISE`=11 in one cycle. Then assert `RESET` for 1 cycle while `PIN[0]` is mid-count toward 0: `LEVEL`=00 after reset, and the count restarts from 0.
- Randomized `PIN` with random `RESET`: assert that `RISE` & `FALL` is always 0, that `LEVEL` only changes with a matching pulse, and that no `LEVEL` change follows fewer than 4 consecutive differing synced samples.
